// File: rtl/key_conditioner_if.sv
// Key conditioner signal bundle: the raw key level in, the conditioned level,
// the event pulse and the auto-repeat flag out.
interface key_conditioner_if;
   logic key;    // raw asynchronous push-button level, 1 = pressed
   logic level;  // debounced key level
   logic pulse;  // single-cycle press or auto-repeat event
   logic held;   // high while auto-repeating

   // Stimulus side: drives the raw key and observes the conditioned outputs
   modport master (
      output key,
      input  level,
      input  pulse,
      input  held
   );

   // Conditioner side
   modport slave (
      input  key,
      output level,
      output pulse,
      output held
   );
endinterface

// File: rtl/key_conditioner.sv
// Push-button conditioner: synchronizes a raw key, debounces it into a stable
// level, and emits a one-cycle pulse on press followed by optional auto-repeat
// pulses while the key stays down. All outputs come straight from flops.
module key_conditioner #(
   parameter int unsigned DB_CYCLES     = 1000000,
   parameter int unsigned REPEAT_DELAY  = 50000000,
   parameter int unsigned REPEAT_PERIOD = 10000000,
   parameter int unsigned REPEAT_EN     = 1
) (
   input logic              clk,
   input logic              rst_n,
   key_conditioner_if.slave bus
);

   // Counter sizing: every count value stays below its limit, so clog2 of the
   // limit is enough bits and no counter can overflow.
   localparam int unsigned DbW    = $clog2(DB_CYCLES);
   localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                   : REPEAT_PERIOD;
   localparam int unsigned RptW   = $clog2(RptMax);

   localparam logic [DbW-1:0]  DbLast     = DbW'(DB_CYCLES - 1);
   localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
   localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);
   localparam logic            RepeatOn   = (REPEAT_EN != 0);

   typedef enum logic [1:0] {
      StIdle,    // key released
      StWait,    // pressed, counting down to the first repeat
      StRepeat   // pressed, auto-repeating
   } state_e;

   // Synchronizer
   logic sync_meta_q;
   logic sync_s_q;

   // Debouncer
   logic [DbW-1:0] db_cnt_q;
   logic [DbW-1:0] db_cnt_d;
   logic           level_q;
   logic           level_d;
   logic           level_rise;
   logic           level_fall;

   // Press / repeat sequencer
   state_e          state_q;
   state_e          state_d;
   logic [RptW-1:0] rpt_cnt_q;
   logic [RptW-1:0] rpt_cnt_d;
   logic            pulse_q;
   logic            pulse_d;
   logic            held_q;
   logic            held_d;

   // ---------------------------------------------------------------------------
   // Synchronizer
   // ---------------------------------------------------------------------------

   // Two-flop synchronizer; sync_s_q is the only view of the key used below
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta_q <= 1'b0;
         sync_s_q    <= 1'b0;
      end else begin
         sync_meta_q <= bus.key;
         sync_s_q    <= sync_meta_q;
      end
   end

   // ---------------------------------------------------------------------------
   // Debouncer
   // ---------------------------------------------------------------------------

   // Count consecutive cycles where the sample disagrees with the accepted
   // level; accept the new value once DB_CYCLES disagreements have been seen.
   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync_s_q != level_q) begin
         if (db_cnt_q == DbLast) begin
            level_d = sync_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DbW'(1);
         end
      end
   end

   // Accepted-level change strobes, aligned with the edge that updates level_q
   assign level_rise = level_d & ~level_q;
   assign level_fall = ~level_d & level_q;

   // Debounce counter and accepted level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         db_cnt_q <= '0;
         level_q  <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Press / repeat sequencer
   // ---------------------------------------------------------------------------

   // Next state, repeat counter and registered-output inputs. A release always
   // takes priority over a repeat expiry on the same edge, so no pulse leaks
   // out as the key goes up.
   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      pulse_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            rpt_cnt_d = '0;
            if (level_rise) begin
               state_d = StWait;
               pulse_d = 1'b1;
            end
         end

         StWait: begin
            if (level_fall) begin
               state_d   = StIdle;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == DelayLast) begin
               if (RepeatOn) begin
                  state_d   = StRepeat;
                  pulse_d   = 1'b1;
                  rpt_cnt_d = '0;
               end
               // Repeat disabled: hold the counter at its limit until release
            end else begin
               rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
         end

         StRepeat: begin
            if (level_fall) begin
               state_d   = StIdle;
               rpt_cnt_d = '0;
            end else if (rpt_cnt_q == PeriodLast) begin
               pulse_d   = 1'b1;
               rpt_cnt_d = '0;
            end else begin
               rpt_cnt_d = rpt_cnt_q + RptW'(1);
            end
         end

         default: begin
            state_d   = StIdle;
            rpt_cnt_d = '0;
         end
      endcase

      held_d = (state_d == StRepeat);
   end

   // Sequencer state, repeat counter and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         rpt_cnt_q <= '0;
         pulse_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rpt_cnt_q <= rpt_cnt_d;
         pulse_q   <= pulse_d;
         held_q    <= held_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------

   assign bus.level = level_q;
   assign bus.pulse = pulse_q;
   assign bus.held  = held_q;

   // ---------------------------------------------------------------------------
   // Internal consistency
   // ---------------------------------------------------------------------------

   // held mirrors the repeat state exactly
   held_tracks_state_a : assert property (@(posedge clk) disable iff (!rst_n)
      held_q == (state_q == StRepeat));

   // The sequencer is only active while the accepted level is high
   idle_when_released_a : assert property (@(posedge clk) disable iff (!rst_n)
      (level_q == 1'b0) |-> (state_q == StIdle));

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 The block SHALL have exactly one clock, clk; reset SHALL be synchronous and active-low, named rst_n.
REQ-002 Parameter DB_CYCLES, default 1000000, SHALL be the consecutive stable cycles required to accept a key change (10 ms at 100 MHz).
REQ-003 Parameter REPEAT_DELAY, default 50000000, SHALL be the cycles from the press pulse to the first auto-repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10000000, SHALL be the cycles between successive auto-repeat pulses.
REQ-005 Parameter REPEAT_EN, default 1, SHALL enable auto-repeat when 1; when 0 the block SHALL emit only the press pulse.
REQ-006 Port clk, input, 1, system clock.
REQ-007 Port rst_n, input, 1, synchronous active-low reset.
REQ-008 Port key, input, 1, raw asynchronous push-button level, 1 = pressed.
REQ-009 Port level, output, 1, debounced key level.
REQ-010 Port pulse, output, 1, single-cycle key event: press or auto-repeat.
REQ-011 Port held, output, 1, high while in auto-repeat.

Function
REQ-012 key SHALL pass through a 2-flop synchronizer; the second flop is the sample s. No other logic SHALL use key directly.
REQ-013 Debounce counter width SHALL be clog2(DB_CYCLES). When s == level, the counter SHALL clear every cycle.
REQ-014 When s != level and counter < DB_CYCLES-1, the counter SHALL increment.
REQ-015 When s != level and counter == DB_CYCLES-1, level SHALL take s and the counter SHALL clear at that edge.
REQ-016 Timing: with E1 the first edge sampling key=1 and key stable thereafter, level SHALL rise at edge E(DB_CYCLES+2). The same timing SHALL apply on release.
REQ-017 Any key disturbance shorter than DB_CYCLES cycles at s SHALL leave level, pulse and held unchanged.
REQ-018 The FSM SHALL have three states. IDLE: level=0. WAIT: pressed, counting REPEAT_DELAY. REPEAT: pressed, counting REPEAT_PERIOD.
REQ-019 On the edge where level rises, the FSM SHALL go IDLE->WAIT. pulse SHALL be high for exactly the following cycle, and the repeat counter SHALL clear.
REQ-020 In WAIT, the counter SHALL count cycles. After REPEAT_DELAY cycles following the press pulse, with REPEAT_EN=1, the FSM SHALL go to REPEAT, pulse SHALL be high for one cycle, and the counter SHALL clear.
REQ-021 In REPEAT, pulse SHALL be high for one cycle every REPEAT_PERIOD cycles; held SHALL be 1 throughout REPEAT and 0 in all other states.
REQ-022 With REPEAT_EN=0, the FSM SHALL stay in WAIT until release, and the counter SHALL saturate instead of wrapping.
REQ-023 On the edge where level falls, the FSM SHALL return to IDLE from any state, with no pulse. If release coincides with repeat-counter expiry, release SHALL win and no pulse SHALL be emitted.
REQ-024 pulse, level and held SHALL be registered outputs with no combinational path from key.
REQ-025 Parameters SHALL be >= 2. Repeat counter width SHALL be clog2(max(REPEAT_DELAY, REPEAT_PERIOD)) with no overflow.

Reset
REQ-026 While rst_n=0 at an edge, the block SHALL clear the synchronizer flops, both counters, level, pulse and held, and set the FSM to IDLE.
REQ-027 Reset mid-press or mid-repeat SHALL abort with no pulse. If key is still held after reset, it SHALL be re-debounced and produce a fresh press pulse per REQ-016/019.

Verification (overrides: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-028 Clean press: key 0->1 sampled at E1 and held for 10 cycles -> level=1 at E6; pulse high only in the cycle after E6; held=0.
REQ-029 Bounce: key toggles 1,0,1,0 on single cycles, then stays 0 -> level, pulse and held stay 0 throughout.
REQ-030 Long hold: key held for 60 cycles after level rises -> pulses at press, +20, +28, +36, +44 and +52 cycles; held=1 from +20 until release.
REQ-031 Release collision: release timed so level falls on the edge a repeat pulse would fire -> no pulse, FSM in IDLE, held=0.
REQ-032 Reset during REPEAT with key held: rst_n=0 for 2 cycles -> all outputs 0. After release of rst_n, a press pulse SHALL occur DB_CYCLES+2 edges later, counting from the first post-reset edge.
REQ-033 REPEAT_EN=0 with key held for 100 cycles -> exactly one pulse and held=0 throughout.
